// File: rtl/timer_bank_pkg.sv
// Shared types and constants for the time-multiplexed 555-style timer bank.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } tmr_state_t;

    localparam logic [1:0] SEL_HIGH = 2'd0;
    localparam logic [1:0] SEL_LOW  = 2'd1;
    localparam logic [1:0] SEL_CTRL = 2'd2;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;

    localparam int LIM_RST = 1000;

endpackage

// File: rtl/timer_slot_update.sv
// Shared count/compare datapath: next state, counter and pending-clear for the channel in the current slot.
//   state | meaning
//   IDLE  | disabled, or monostable waiting for a trigger
//   HIGH  | output high, counting toward HIGH limit
//   LOW   | astable output low, counting toward LOW limit
module timer_slot_update
    import timer_bank_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  tmr_state_t       i_state,
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_high_cnt,
    input  logic [CNT_W-1:0] i_low_cnt,
    input  logic [1:0]       i_ctrl,
    input  logic             i_pend,
    output tmr_state_t       o_state,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_pend_clr
);

    logic [CNT_W-1:0] w_high_lim;
    logic [CNT_W-1:0] w_low_lim;
    logic             w_hit_high;
    logic             w_hit_low;

    // A programmed limit of 0 behaves as 1.
    assign w_high_lim = (i_high_cnt == '0) ? CNT_W'(1) : i_high_cnt;
    assign w_low_lim  = (i_low_cnt == '0) ? CNT_W'(1) : i_low_cnt;
    assign w_hit_high = (i_cnt == w_high_lim - CNT_W'(1));
    assign w_hit_low  = (i_cnt == w_low_lim - CNT_W'(1));

    always_comb begin
        o_state    = i_state;
        o_cnt      = i_cnt;
        o_pend_clr = 1'b0;
        if (!i_ctrl[CTRL_EN]) begin
            o_state = IDLE;
            o_cnt   = '0;
        end else begin
            case (i_state)
                IDLE: begin
                    if (!i_ctrl[CTRL_MODE] || i_pend) begin
                        o_state    = HIGH;
                        o_cnt      = '0;
                        o_pend_clr = i_ctrl[CTRL_MODE];
                    end
                end
                HIGH: begin
                    o_pend_clr = 1'b1;
                    if (w_hit_high) begin
                        o_state = i_ctrl[CTRL_MODE] ? IDLE : LOW;
                        o_cnt   = '0;
                    end else begin
                        o_cnt = i_cnt + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (i_ctrl[CTRL_MODE]) begin
                        o_state = IDLE;
                        o_cnt   = '0;
                    end else if (w_hit_low) begin
                        o_state = HIGH;
                        o_cnt   = '0;
                    end else begin
                        o_cnt = i_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    o_state = IDLE;
                    o_cnt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/timer_bank_ctrl.sv
// Round-robin timer bank: per-channel registers, slot pointer, config write decode and output register.
module timer_bank_ctrl
    import timer_bank_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cfg_we,
    input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
    input  logic [1:0]                  cfg_sel,
    input  logic [CNT_W-1:0]            cfg_data,
    input  logic [CHANNELS-1:0]         trig,
    output logic [CHANNELS-1:0]         out,
    output logic [$clog2(CHANNELS)-1:0] slot
);

    localparam int               SW        = $clog2(CHANNELS);
    localparam logic [SW-1:0]    SLOT_LAST = SW'(CHANNELS - 1);
    localparam logic [CNT_W-1:0] LIM_INIT  = CNT_W'(LIM_RST);

    logic [SW-1:0]      r_slot;
    tmr_state_t         r_state  [CHANNELS];
    logic [CNT_W-1:0]   r_cnt    [CHANNELS];
    logic [CNT_W-1:0]   r_high   [CHANNELS];
    logic [CNT_W-1:0]   r_low    [CHANNELS];
    logic [1:0]         r_ctrl   [CHANNELS];
    logic [CHANNELS-1:0] r_pend;
    logic [CHANNELS-1:0] r_out;

    logic [CHANNELS-1:0] w_wr_high;
    logic [CHANNELS-1:0] w_wr_low;
    logic [CHANNELS-1:0] w_wr_ctrl;
    logic [CHANNELS-1:0] w_svc;
    tmr_state_t          w_nxt_state;
    logic [CNT_W-1:0]    w_nxt_cnt;
    logic                w_pend_clr;

    always_comb begin
        w_wr_high = '0;
        w_wr_low  = '0;
        w_wr_ctrl = '0;
        w_svc     = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            w_wr_high[c] = cfg_we && (cfg_ch == SW'(c)) && (cfg_sel == SEL_HIGH);
            w_wr_low[c]  = cfg_we && (cfg_ch == SW'(c)) && (cfg_sel == SEL_LOW);
            w_wr_ctrl[c] = cfg_we && (cfg_ch == SW'(c)) && (cfg_sel == SEL_CTRL);
            w_svc[c]     = (r_slot == SW'(c));
        end
    end

    timer_slot_update #(
        .CNT_W (CNT_W)
    ) u_slot_update (
        .i_state    (r_state[r_slot]),
        .i_cnt      (r_cnt[r_slot]),
        .i_high_cnt (r_high[r_slot]),
        .i_low_cnt  (r_low[r_slot]),
        .i_ctrl     (r_ctrl[r_slot]),
        .i_pend     (r_pend[r_slot]),
        .o_state    (w_nxt_state),
        .o_cnt      (w_nxt_cnt),
        .o_pend_clr (w_pend_clr)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_slot <= '0;
            r_pend <= '0;
            r_out  <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_state[c] <= IDLE;
                r_cnt[c]   <= '0;
                r_high[c]  <= LIM_INIT;
                r_low[c]   <= LIM_INIT;
                r_ctrl[c]  <= '0;
            end
        end else begin
            r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + SW'(1);
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_wr_high[c]) r_high[c] <= cfg_data;
                if (w_wr_low[c])  r_low[c]  <= cfg_data;
                // A CTRL write overrides any service of the same channel in this cycle.
                if (w_wr_ctrl[c]) begin
                    r_ctrl[c]  <= cfg_data[1:0];
                    r_state[c] <= IDLE;
                    r_cnt[c]   <= '0;
                    r_pend[c]  <= 1'b0;
                    r_out[c]   <= 1'b0;
                end else begin
                    if (w_svc[c]) begin
                        r_state[c] <= w_nxt_state;
                        r_cnt[c]   <= w_nxt_cnt;
                        r_out[c]   <= (w_nxt_state == HIGH);
                    end
                    r_pend[c] <= (w_svc[c] && w_pend_clr) ? 1'b0 : (r_pend[c] | trig[c]);
                end
            end
        end
    end

    assign out  = r_out;
    assign slot = r_slot;

endmodule

// File: tb/tb_timer_bank_ctrl.sv
// Directed timing checks plus a randomized run against a phase-level reference model.
module tb_timer_bank_ctrl;
    import timer_bank_pkg::*;

    localparam int CH = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [1:0]    cfg_sel;
    logic [CW-1:0] cfg_data;
    logic [CH-1:0] trig;
    logic [CH-1:0] out;
    logic [1:0]    slot;

    int n_chk = 0;
    int n_err = 0;

    // reference model: phase 0 idle, 1 high, 2 low; srv = services spent in phase
    int m_ph   [CH];
    int m_srv  [CH];
    int m_hi   [CH];
    int m_lo   [CH];
    int m_ctrl [CH];
    bit m_pend [CH];
    int m_slot;

    always #5 clk = ~clk;

    timer_bank_ctrl #(.CHANNELS(CH), .CNT_W(CW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .trig     (trig),
        .out      (out),
        .slot     (slot)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input int sel, input int data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_sel  = 2'(sel);
        cfg_data = CW'(data);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic measure(input int idx, input logic lvl, input int max, output int n);
        n = 0;
        while (n < max && out[idx] === lvl) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_for(input int idx, input logic lvl, input int max, output int n);
        n = 0;
        while (n < max && out[idx] !== lvl) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic hold_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic model_init();
        for (int c = 0; c < CH; c++) begin
            m_ph[c] = 0; m_srv[c] = 0; m_pend[c] = 0;
            m_hi[c] = LIM_RST; m_lo[c] = LIM_RST; m_ctrl[c] = 0;
        end
        m_slot = 0;
    endtask

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            bit clr;
            bit mono;
            int hl;
            int ll;
            clr  = 0;
            mono = (m_ctrl[c] & 2) != 0;
            hl   = (m_hi[c] == 0) ? 1 : m_hi[c];
            ll   = (m_lo[c] == 0) ? 1 : m_lo[c];
            if (cfg_we && cfg_ch == c && cfg_sel == SEL_CTRL) begin
                m_ctrl[c] = int'(cfg_data[1:0]);
                m_ph[c] = 0; m_srv[c] = 0; m_pend[c] = 0;
            end else begin
                if (m_slot == c) begin
                    if ((m_ctrl[c] & 1) == 0) begin
                        m_ph[c] = 0; m_srv[c] = 0;
                    end else if (m_ph[c] == 0) begin
                        if (!mono || m_pend[c]) begin
                            m_ph[c] = 1; m_srv[c] = 0; clr = mono;
                        end
                    end else if (m_ph[c] == 1) begin
                        clr = 1;
                        m_srv[c]++;
                        if (m_srv[c] % 65536 == hl) begin
                            m_ph[c] = mono ? 0 : 2; m_srv[c] = 0;
                        end
                    end else begin
                        m_srv[c]++;
                        if (mono) begin
                            m_ph[c] = 0; m_srv[c] = 0;
                        end else if (m_srv[c] % 65536 == ll) begin
                            m_ph[c] = 1; m_srv[c] = 0;
                        end
                    end
                end
                m_pend[c] = clr ? 1'b0 : (m_pend[c] | trig[c]);
            end
            if (cfg_we && cfg_ch == c && cfg_sel == SEL_HIGH) m_hi[c] = int'(cfg_data);
            if (cfg_we && cfg_ch == c && cfg_sel == SEL_LOW)  m_lo[c] = int'(cfg_data);
        end
        m_slot = (m_slot + 1) % CH;
    endtask

    function automatic logic [CH-1:0] model_out();
        logic [CH-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) v[c] = (m_ph[c] == 1);
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        reset_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0; trig = '0;

        // reset values and slot sequence
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", out, 0);
        check("rst_slot", slot, 0);
        reset_n = 1'b1;
        check("slot_0", slot, 0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("slot_seq", slot, i % CH);
        end

        // astable ch1 H=2 L=3
        cfg_write(1, SEL_HIGH, 2);
        cfg_write(1, SEL_LOW, 3);
        cfg_write(1, SEL_CTRL, 1);
        wait_for(1, 1'b1, 100, n);
        check("ast_rise", 32'(n < 100), 1);
        measure(1, 1'b1, 100, n); check("ast_high", n, 8);
        measure(1, 1'b0, 100, n); check("ast_low", n, 12);
        check("ast_others", out & 4'b1101, 0);
        measure(1, 1'b1, 100, n); check("ast_high2", n, 8);
        cfg_write(1, SEL_CTRL, 0);

        // zero limits on ch0
        cfg_write(0, SEL_HIGH, 0);
        cfg_write(0, SEL_LOW, 0);
        cfg_write(0, SEL_CTRL, 1);
        wait_for(0, 1'b1, 100, n);
        check("zero_rise", 32'(n < 100), 1);
        measure(0, 1'b1, 100, n); check("zero_high", n, 4);
        measure(0, 1'b0, 100, n); check("zero_low", n, 4);
        cfg_write(0, SEL_CTRL, 0);

        // monostable ch2 H=5 with retrigger during the pulse
        cfg_write(2, SEL_HIGH, 5);
        cfg_write(2, SEL_CTRL, 3);
        @(negedge clk); trig = 4'b0100;
        @(negedge clk); trig = 4'b0000;
        wait_for(2, 1'b1, 20, n);
        check("mono_latency", 32'(n >= 1 && n <= CH), 1);
        n = 0;
        while (n < 60 && out[2]) begin
            n++;
            trig = (n == 8) ? 4'b0100 : 4'b0000;
            @(negedge clk);
        end
        trig = 4'b0000;
        check("mono_high", n, 20);
        k = 0;
        repeat (60) begin
            @(negedge clk);
            if (out[2]) k++;
        end
        check("mono_no_repulse", k, 0);
        cfg_write(2, SEL_CTRL, 0);

        // CTRL write mid-pulse coinciding with ch3 service
        cfg_write(3, SEL_HIGH, 4);
        cfg_write(3, SEL_LOW, 4);
        cfg_write(3, SEL_CTRL, 1);
        wait_for(3, 1'b1, 100, n);
        k = 0;
        while (k < 20 && !(slot == 2'd3 && out[3])) begin
            @(negedge clk);
            k++;
        end
        check("ctrl_sync", 32'(k < 20), 1);
        cfg_we = 1'b1; cfg_ch = 2'd3; cfg_sel = SEL_CTRL; cfg_data = CW'(1);
        @(negedge clk);
        cfg_we = 1'b0;
        check("ctrl_kill", out[3], 0);
        wait_for(3, 1'b1, 20, n);
        check("ctrl_restart", n, 4);
        cfg_write(3, SEL_CTRL, 0);

        // lowering HIGH below the running count: channel holds high
        cfg_write(1, SEL_HIGH, 8);
        cfg_write(1, SEL_LOW, 8);
        cfg_write(1, SEL_CTRL, 1);
        wait_for(1, 1'b1, 100, n);
        fork
            measure(1, 1'b1, 80, n);
            begin
                repeat (15) @(negedge clk);
                cfg_write(1, SEL_HIGH, 3);
            end
        join
        check("lim_wrap_hold", n, 80);

        // reset mid-pulse, configuration lost
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_out", out, 0);
        check("rst_mid_slot", slot, 0);
        @(negedge clk);
        reset_n = 1'b1;
        k = 0;
        repeat (40) begin
            @(negedge clk);
            if (out != 0) k++;
        end
        check("rst_cfg_lost", k, 0);

        // raising HIGH mid-count extends the pulse to the new limit
        cfg_write(1, SEL_HIGH, 8);
        cfg_write(1, SEL_LOW, 8);
        cfg_write(1, SEL_CTRL, 1);
        wait_for(1, 1'b1, 100, n);
        fork
            measure(1, 1'b1, 200, n);
            begin
                repeat (15) @(negedge clk);
                cfg_write(1, SEL_HIGH, 10);
            end
        join
        check("lim_extend", n, 40);

        // reset-default limit of 1000
        hold_reset();
        cfg_write(0, SEL_CTRL, 1);
        wait_for(0, 1'b1, 20, n);
        check("dflt_rise", 32'(n < 20), 1);
        measure(0, 1'b1, 4100, n);
        check("dflt_high", n, 4000);

        // randomized run against the model
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_init();
        for (int i = 0; i < 3000; i++) begin
            cfg_we  = ($urandom_range(0, 7) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_sel = 2'($urandom_range(0, 3));
            cfg_data = (cfg_sel == SEL_CTRL) ? CW'($urandom_range(0, 3)) : CW'($urandom_range(0, 6));
            for (int b = 0; b < CH; b++) trig[b] = ($urandom_range(0, 9) == 0);
            model_step();
            @(posedge clk);
            #1;
            check("rnd_out", out, model_out());
            check("rnd_slot", slot, m_slot);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        trig   = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
